multi_edge_detect: RTL and testbench
====================================

// Module: multi_edge_detect
// PURPOSE
//  Parametrised multi-channel edge detector for asynchronous level inputs (buttons, external strobes, status pins).
//  Per channel: input synchroniser, glitch filter, registered rise/fall pulses, per-channel mode select,
//  sticky event flags with clear, and one combined interrupt. Sits between raw pins and the control/status logic.
// PARAMETERS
//  WIDTH        8  number of independent channels (>=1)
//  SYNC_STAGES  2  synchroniser flops per channel (>=2)
//  FILT_LEN     4  consecutive cycles a new level must persist before it is accepted (>=1; 1 = no filtering)
// PORTS
//  clk       in   1        single clock; all state updates on posedge
//  rst       in   1        synchronous, active-high reset
//  a_i       in   WIDTH    raw asynchronous inputs
//  mode_i    in   2*WIDTH  per channel [2c+1:2c]: 00 off, 01 rise, 10 fall, 11 both
//  clr_i     in   WIDTH    write-1-to-clear pulse for status_o bits
//  irq_en_i  in   WIDTH    per-channel interrupt enable
//  level_o   out  WIDTH    filtered, synchronised level
//  rise_o    out  WIDTH    1-cycle pulse on filtered 0->1 (ignores mode)
//  fall_o    out  WIDTH    1-cycle pulse on filtered 1->0 (ignores mode)
//  evt_o     out  WIDTH    1-cycle pulse: (rise_o & mode[0]) | (fall_o & mode[1])
//  status_o  out  WIDTH    sticky event flags
//  irq_o     out  1        |(status_o & irq_en_i), combinational from registers
// BEHAVIOUR
//  - Reset: sync chain, level_o, filter counters, rise_o, fall_o, evt_o, status_o all 0; irq_o therefore 0.
//  - Sync: s = last flop of the SYNC_STAGES chain. No logic on a_i before the first flop.
//  - Filter, per channel, counter cnt (width max(1,$clog2(FILT_LEN))):
//      s == level_o                      -> cnt <= 0
//      s != level_o, cnt <  FILT_LEN-1   -> cnt <= cnt+1
//      s != level_o, cnt == FILT_LEN-1   -> level_o <= s, cnt <= 0, accept
//    Glitch shorter than FILT_LEN cycles at s: counter clears, no level change, no pulses.
//  - Pulses are registered at the accept edge: rise_o <= accept & s; fall_o <= accept & ~s; high exactly 1 cycle,
//    in the same cycle level_o shows the new value. Never both high on one channel.
//  - Latency: pulse visible after SYNC_STAGES+FILT_LEN posedges, counting the first edge that samples the new a_i level as 1.
//  - Minimum accepted toggle period: 2*FILT_LEN cycles; no edge lost or merged above that.
//  - evt_o uses mode_i sampled at the accept edge; mode changes take effect immediately, no history.
//    mode 00: evt_o/status_o never set, rise_o/fall_o/level_o still track.
//  - status_o[c] <= (status_o[c] & ~clr_i[c]) | evt_next[c]; set wins over a simultaneous clear.
//  - Reset mid-operation: all state returns to reset value on the next edge; in-progress filter counts discarded.
//    After reset level_o = 0, so an input held high through reset yields one rise after the normal latency.
//  - Channels fully independent; simultaneous events on any set of channels are all reported the same cycle.
// STRUCTURE
//  - Package multi_edge_pkg: localparam mode encodings (MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11),
//    typedef edge_mode_t logic[1:0].
//  - Sub-module edge_chan: one channel (sync chain, filter counter, level, rise/fall/evt, status bit), params SYNC_STAGES/FILT_LEN.
//  - Top multi_edge_detect: generate loop of WIDTH edge_chan instances plus the irq_o OR-reduction.
// TESTING (WIDTH=8, SYNC_STAGES=2, FILT_LEN=4 unless noted)
//  1. a_i[0] 0->1 held, mode=01 -> rise_o[0]/evt_o[0] high 1 cycle after 6 edges, status_o[0]=1, level_o[0]=1; fall_o stays 0.
//  2. a_i[1] high for 3 cycles then low, mode=11 -> no rise/fall/evt, level_o[1] stays 0; high 4 cycles -> one rise, then fall.
//  3. mode=10 on ch2, full pulse 0->1->0 (8 cycles each) -> rise_o[2] and fall_o[2] pulse; evt_o[2]/status_o[2] only on fall.
//  4. status_o[3]=1, irq_en_i=8'h08 -> irq_o=1; clr_i[3] pulse -> status_o[3]=0, irq_o=0 next cycle; clr_i[3] in same cycle as new evt -> status_o[3] stays 1.
//  5. a_i=8'hFF at once, mode all 11 -> rise_o=8'hFF in one cycle, status_o=8'hFF; rst asserted mid-filter on a second toggle -> all outputs 0, no pulse.
//  6. FILT_LEN=1, a_i[0] toggles every 2 cycles -> exactly one pulse per toggle, alternating rise/fall, 3-edge latency.

Source files
------------

// File: rtl/multi_edge_pkg.sv
// Shared types and mode encodings for the multi-channel edge detector.
package multi_edge_pkg;

    typedef logic [1:0] edge_mode_t;

    localparam edge_mode_t MODE_OFF  = 2'b00;
    localparam edge_mode_t MODE_RISE = 2'b01;
    localparam edge_mode_t MODE_FALL = 2'b10;
    localparam edge_mode_t MODE_BOTH = 2'b11;

endpackage

// File: rtl/edge_chan.sv
// One edge-detect channel: synchroniser, persistence filter, registered edge pulses
// and a sticky event flag.
module edge_chan
    import multi_edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  edge_mode_t mode,
    input  logic       clr,
    output logic       level,
    output logic       rise,
    output logic       fall,
    output logic       evt,
    output logic       status
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   s;
    logic                   accept;
    logic                   evt_next;

    assign s      = sync_q[SYNC_STAGES-1];
    assign accept = (s != level) && (cnt_q == CNT_MAX);

    // Mode is taken live at the accept edge; there is no latched copy.
    assign evt_next = accept &&
                      (( s && (mode == MODE_RISE || mode == MODE_BOTH)) ||
                       (!s && (mode == MODE_FALL || mode == MODE_BOTH)));

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
            evt    <= 1'b0;
            status <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], a};
            if (s == level || accept) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (accept) begin
                level <= s;
            end
            rise   <= accept & s;
            fall   <= accept & ~s;
            evt    <= evt_next;
            status <= (status & ~clr) | evt_next;
        end
    end

endmodule

// File: rtl/multi_edge_detect.sv
// Multi-channel filtered edge detector: one edge_chan per input plus a masked
// interrupt over the sticky status flags.
module multi_edge_detect
    import multi_edge_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [2*WIDTH-1:0] mode_i,
    input  logic [WIDTH-1:0]   clr_i,
    input  logic [WIDTH-1:0]   irq_en_i,
    output logic [WIDTH-1:0]   level_o,
    output logic [WIDTH-1:0]   rise_o,
    output logic [WIDTH-1:0]   fall_o,
    output logic [WIDTH-1:0]   evt_o,
    output logic [WIDTH-1:0]   status_o,
    output logic               irq_o
);

    for (genvar c = 0; c < WIDTH; c++) begin : g_chan
        edge_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_LEN   (FILT_LEN)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .a     (a_i[c]),
            .mode  (edge_mode_t'(mode_i[2*c +: 2])),
            .clr   (clr_i[c]),
            .level (level_o[c]),
            .rise  (rise_o[c]),
            .fall  (fall_o[c]),
            .evt   (evt_o[c]),
            .status(status_o[c])
        );
    end

    assign irq_o = |(status_o & irq_en_i);

endmodule

// File: tb/tb_multi_edge_detect.sv
// Bench for multi_edge_detect: window-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_multi_edge_detect;

    localparam int W  = 8;
    localparam int SS = 2;
    localparam int FL = 4;

    logic           clk;
    logic           rst;
    logic [W-1:0]   a_i;
    logic [2*W-1:0] mode_i;
    logic [W-1:0]   clr_i;
    logic [W-1:0]   irq_en_i;
    logic [W-1:0]   level_o, rise_o, fall_o, evt_o, status_o;
    logic           irq_o;

    logic [0:0] a1, clr1, irq_en1;
    logic [1:0] mode1;
    logic [0:0] level1, rise1, fall1, evt1, status1;
    logic       irq1;

    int tests = 0;
    int fails = 0;
    bit chk_on = 0;

    multi_edge_detect #(.WIDTH(W), .SYNC_STAGES(SS), .FILT_LEN(FL)) dut (
        .clk(clk), .rst(rst), .a_i(a_i), .mode_i(mode_i), .clr_i(clr_i),
        .irq_en_i(irq_en_i), .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o),
        .evt_o(evt_o), .status_o(status_o), .irq_o(irq_o)
    );

    multi_edge_detect #(.WIDTH(1), .SYNC_STAGES(2), .FILT_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .a_i(a1), .mode_i(mode1), .clr_i(clr1),
        .irq_en_i(irq_en1), .level_o(level1), .rise_o(rise1), .fall_o(fall1),
        .evt_o(evt1), .status_o(status1), .irq_o(irq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a_hist holds raw samples, s_hist the synchronised values seen
    // at the last FL edges. A level is accepted when the whole window disagrees with it.
    bit [SS-1:0] a_hist [W];
    bit [FL-1:0] s_hist [W];
    bit [W-1:0]  m_level, m_rise, m_fall, m_evt, m_status;
    bit          s_now, acc;
    logic [1:0]  md;

    always @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < W; c++) begin
                a_hist[c] = '0;
                s_hist[c] = '0;
            end
            m_level = '0; m_rise = '0; m_fall = '0; m_evt = '0; m_status = '0;
        end else begin
            for (int c = 0; c < W; c++) begin
                s_now     = a_hist[c][SS-1];
                s_hist[c] = {s_hist[c][FL-2:0], s_now};
                acc       = (s_hist[c] == {FL{~m_level[c]}});
                a_hist[c] = {a_hist[c][SS-2:0], a_i[c]};
                md        = mode_i[2*c +: 2];
                m_rise[c]   = acc & s_now;
                m_fall[c]   = acc & ~s_now;
                m_evt[c]    = (m_rise[c] & md[0]) | (m_fall[c] & md[1]);
                m_status[c] = m_evt[c] | (m_status[c] & ~clr_i[c]);
                if (acc) m_level[c] = s_now;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_level",  64'(level_o),  64'(m_level));
            chk("model_rise",   64'(rise_o),   64'(m_rise));
            chk("model_fall",   64'(fall_o),   64'(m_fall));
            chk("model_evt",    64'(evt_o),    64'(m_evt));
            chk("model_status", 64'(status_o), 64'(m_status));
            chk("model_irq",    64'(irq_o),    64'(|(m_status & irq_en_i)));
        end
    end

    task automatic to_drive();
        @(negedge clk);
        #2;
    endtask

    task automatic count_pulses(input int c, input int n, output int nr, output int nf, output int ne);
        nr = 0; nf = 0; ne = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            nr += int'(rise_o[c]);
            nf += int'(fall_o[c]);
            ne += int'(evt_o[c]);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish, limit 1ms");
        $fatal(1, "timeout");
    end

    initial begin
        int nr, nf, ne, n, hits, seq_err, first;
        bit found, exp_rise;
        int hold [W];

        rst = 1'b1; a_i = '0; mode_i = '0; clr_i = '0; irq_en_i = '0;
        a1 = '0; mode1 = 2'b11; clr1 = '0; irq_en1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1;
        chk("reset_outputs", 64'({level_o, rise_o, fall_o, evt_o, status_o}), 64'd0);
        chk("reset_irq", 64'(irq_o), 64'd0);
        to_drive();
        rst = 1'b0;
        repeat (3) @(posedge clk);

        // 1: rise on ch0 in rise mode, latency SYNC+FILT edges
        to_drive();
        mode_i[1:0] = 2'b01; a_i[0] = 1'b1;
        found = 0; n = 0;
        for (int i = 1; i <= 20 && !found; i++) begin
            @(posedge clk); #1;
            if (fall_o[0]) chk("t1_no_fall", 64'(fall_o[0]), 64'd0);
            if (rise_o[0]) begin
                found = 1; n = i;
                chk("t1_evt", 64'(evt_o[0]), 64'd1);
                chk("t1_level", 64'(level_o[0]), 64'd1);
            end
        end
        chk("t1_latency", 64'(n), 64'd6);
        @(posedge clk); #1;
        chk("t1_status", 64'(status_o[0]), 64'd1);
        chk("t1_rise_one_cycle", 64'(rise_o[0]), 64'd0);

        // 2: 3-cycle glitch rejected, 4-cycle pulse accepted
        to_drive();
        mode_i[3:2] = 2'b11; a_i[1] = 1'b1;
        repeat (3) @(posedge clk);
        to_drive();
        a_i[1] = 1'b0;
        count_pulses(1, 15, nr, nf, ne);
        chk("t2_glitch_pulses", 64'(nr + nf + ne), 64'd0);
        chk("t2_glitch_level", 64'(level_o[1]), 64'd0);
        to_drive();
        a_i[1] = 1'b1;
        repeat (4) @(posedge clk);
        to_drive();
        a_i[1] = 1'b0;
        count_pulses(1, 20, nr, nf, ne);
        chk("t2_rise_count", 64'(nr), 64'd1);
        chk("t2_fall_count", 64'(nf), 64'd1);
        chk("t2_evt_count", 64'(ne), 64'd2);

        // 3: fall-only mode
        to_drive();
        mode_i[5:4] = 2'b10; a_i[2] = 1'b1;
        count_pulses(2, 8, nr, nf, ne);
        chk("t3_rise", 64'(nr), 64'd1);
        chk("t3_evt_on_rise", 64'(ne), 64'd0);
        chk("t3_status_after_rise", 64'(status_o[2]), 64'd0);
        to_drive();
        a_i[2] = 1'b0;
        count_pulses(2, 8, nr, nf, ne);
        chk("t3_fall", 64'(nf), 64'd1);
        chk("t3_evt_on_fall", 64'(ne), 64'd1);
        chk("t3_status_after_fall", 64'(status_o[2]), 64'd1);

        // 4: irq, clear, and set winning over a simultaneous clear
        to_drive();
        mode_i[7:6] = 2'b11; a_i[3] = 1'b1; irq_en_i = 8'h08;
        count_pulses(3, 8, nr, nf, ne);
        chk("t4_rise", 64'(nr), 64'd1);
        chk("t4_status", 64'(status_o[3]), 64'd1);
        chk("t4_irq_set", 64'(irq_o), 64'd1);
        to_drive();
        clr_i = 8'h08;
        @(posedge clk); #1;
        chk("t4_status_cleared", 64'(status_o[3]), 64'd0);
        chk("t4_irq_cleared", 64'(irq_o), 64'd0);
        to_drive();
        clr_i = '0; a_i[3] = 1'b0;
        repeat (5) @(posedge clk);
        to_drive();
        clr_i = 8'h08;
        @(posedge clk); #1;
        chk("t4_evt_with_clr", 64'(evt_o[3]), 64'd1);
        chk("t4_set_wins", 64'(status_o[3]), 64'd1);
        chk("t4_irq_again", 64'(irq_o), 64'd1);
        to_drive();
        clr_i = '0;

        // 5: all channels at once, then reset in the middle of a filter count
        to_drive();
        a_i = '0; mode_i = 16'hFFFF;
        repeat (12) @(posedge clk);
        to_drive();
        clr_i = 8'hFF;
        to_drive();
        clr_i = '0; a_i = 8'hFF;
        found = 0;
        for (int i = 1; i <= 20 && !found; i++) begin
            @(posedge clk); #1;
            if (rise_o != '0) begin
                found = 1;
                chk("t5_rise_all", 64'(rise_o), 64'hFF);
                chk("t5_evt_all", 64'(evt_o), 64'hFF);
                chk("t5_status_all", 64'(status_o), 64'hFF);
            end
        end
        chk("t5_rise_seen", 64'(found), 64'd1);
        to_drive();
        a_i = '0;
        repeat (3) @(posedge clk);
        to_drive();
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t5_reset_outputs", 64'({level_o, rise_o, fall_o, evt_o, status_o}), 64'd0);
        chk("t5_reset_irq", 64'(irq_o), 64'd0);
        to_drive();
        rst = 1'b0;
        hits = 0;
        repeat (15) begin
            @(posedge clk); #1;
            hits += $countones({rise_o, fall_o});
        end
        chk("t5_no_pulse_after_reset", 64'(hits), 64'd0);

        // 6: FILT_LEN=1 instance, toggle every 2 cycles
        to_drive();
        a1 = ~a1;
        hits = 0; seq_err = 0; first = 0; exp_rise = 1;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (rise1[0] && fall1[0]) seq_err++;
            if (rise1[0] || fall1[0]) begin
                hits++;
                if (first == 0) first = i;
                if (rise1[0] != exp_rise) seq_err++;
                exp_rise = ~exp_rise;
            end
            if (i % 2 == 0) begin
                to_drive();
                a1 = ~a1;
            end
        end
        chk("t6_first_latency", 64'(first), 64'd3);
        chk("t6_pulse_count", 64'(hits), 64'd7);
        chk("t6_alternation", 64'(seq_err), 64'd0);

        // Randomized traffic, checked by the model every cycle
        for (int c = 0; c < W; c++) hold[c] = $urandom_range(1, 12);
        for (int k = 0; k < 2000; k++) begin
            to_drive();
            for (int c = 0; c < W; c++) begin
                if (hold[c] == 0) begin
                    a_i[c]  = ~a_i[c];
                    hold[c] = $urandom_range(1, 12);
                end else begin
                    hold[c]--;
                end
            end
            if ($urandom_range(0, 15) == 0) mode_i = 16'($urandom);
            if ($urandom_range(0, 31) == 0) irq_en_i = 8'($urandom);
            clr_i = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            rst   = ($urandom_range(0, 299) == 0);
        end
        to_drive();
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
